// File: rtl/vga_timing_pipeline.sv
// VGA raster timing generator with a latency-matched sync/DE/RGB output stage and a
// frame-boundary double-buffer swap. Optional colour-bar source: VGA_TEST_PATTERN_EN.
module vga_timing_pipeline #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   COLOR_W  = 4,
  parameter int   PIPE_LAT = 2,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW       = $clog2(H_TOTAL),
  localparam int  VW       = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   pattern_sel,
`endif
  output logic [HW-1:0]          pix_x,
  output logic [VW-1:0]          pix_y,
  output logic                   fetch_valid,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   buf_sel,
  output logic                   frame_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue
);

  localparam int RGB_W    = 3 * COLOR_W;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic              buf_sel_q, buf_sel_d;
  logic [PIPE_LAT:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_LAT:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_LAT:0] de_pipe_q, de_pipe_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;

  logic              run_s;
  logic              line_end_s;
  logic              frame_end_s;
  logic              fetch_valid_s;
  logic              frame_start_s;
  logic              swap_ack_s;
  logic              hs_raw_s;
  logic              vs_raw_s;
  logic              de_tap_s;
  logic [RGB_W-1:0]  rgb_src_s;

  // Raw timing decode from this cycle's counter values; reset or disable forces inactive.
  always_comb begin
    run_s         = enable & ~rst;
    line_end_s    = (h_cnt_q == H_LAST);
    frame_end_s   = line_end_s & (v_cnt_q == V_LAST);
    fetch_valid_s = run_s & (int'(h_cnt_q) < H_ACTIVE) & (int'(v_cnt_q) < V_ACTIVE);
    frame_start_s = run_s & (h_cnt_q == '0) & (v_cnt_q == '0);
    swap_ack_s    = run_s & frame_end_s & swap_req;
    hs_raw_s      = ~H_POL;
    vs_raw_s      = ~V_POL;
    if (run_s && (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END)) begin
      hs_raw_s = H_POL;
    end else begin
      hs_raw_s = ~H_POL;
    end
    if (run_s && (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END)) begin
      vs_raw_s = V_POL;
    end else begin
      vs_raw_s = ~V_POL;
    end
  end

  // Counter advance: parked at origin while disabled, line and frame wrap otherwise.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (line_end_s) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  // Buffer flip lands together with the counter wrap to origin.
  always_comb begin
    buf_sel_d = buf_sel_q;
    if (swap_ack_s) begin
      buf_sel_d = ~buf_sel_q;
    end else begin
      buf_sel_d = buf_sel_q;
    end
  end

  // Sync/DE delay lines: stage k holds the raw value from k+1 cycles ago.
  always_comb begin
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    de_pipe_d    = de_pipe_q;
    hs_pipe_d[0] = hs_raw_s;
    vs_pipe_d[0] = vs_raw_s;
    de_pipe_d[0] = fetch_valid_s;
    for (int k = 1; k <= PIPE_LAT; k++) begin
      hs_pipe_d[k] = hs_pipe_q[k-1];
      vs_pipe_d[k] = vs_pipe_q[k-1];
      de_pipe_d[k] = de_pipe_q[k-1];
    end
  end

  // Fetch-valid as seen when the frame-store data for that fetch arrives.
  generate
    if (PIPE_LAT == 0) begin : g_de_tap_raw
      assign de_tap_s = fetch_valid_s;
    end else begin : g_de_tap_pipe
      assign de_tap_s = de_pipe_q[PIPE_LAT-1];
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  logic [HW-1:0]    x_dly_s;
  logic [2:0]       bar_idx_s;
  logic [RGB_W-1:0] bar_rgb_s;

  function automatic logic [RGB_W-1:0] bar_color(input logic r, input logic g, input logic b);
    return {{COLOR_W{r}}, {COLOR_W{g}}, {COLOR_W{b}}};
  endfunction

  generate
    if (PIPE_LAT == 0) begin : g_x_raw
      assign x_dly_s = h_cnt_q;
    end else begin : g_x_pipe
      logic [HW-1:0] x_pipe_q [PIPE_LAT];
      logic [HW-1:0] x_pipe_d [PIPE_LAT];

      // Column delay line matching the frame-store latency.
      always_comb begin
        x_pipe_d    = x_pipe_q;
        x_pipe_d[0] = h_cnt_q;
        for (int k = 1; k < PIPE_LAT; k++) begin
          x_pipe_d[k] = x_pipe_q[k-1];
        end
      end

      // Column delay registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < PIPE_LAT; k++) begin
            x_pipe_q[k] <= '0;
          end
        end else begin
          x_pipe_q <= x_pipe_d;
        end
      end

      assign x_dly_s = x_pipe_q[PIPE_LAT-1];
    end
  endgenerate

  // Eight equal-width vertical bars across the active width.
  always_comb begin
    bar_idx_s = 3'((int'(x_dly_s) * 32'sd8) / H_ACTIVE);
    case (bar_idx_s)
      3'd0:    bar_rgb_s = bar_color(1'b1, 1'b1, 1'b1);
      3'd1:    bar_rgb_s = bar_color(1'b1, 1'b1, 1'b0);
      3'd2:    bar_rgb_s = bar_color(1'b0, 1'b1, 1'b1);
      3'd3:    bar_rgb_s = bar_color(1'b0, 1'b1, 1'b0);
      3'd4:    bar_rgb_s = bar_color(1'b1, 1'b0, 1'b1);
      3'd5:    bar_rgb_s = bar_color(1'b1, 1'b0, 1'b0);
      3'd6:    bar_rgb_s = bar_color(1'b0, 1'b0, 1'b1);
      default: bar_rgb_s = bar_color(1'b0, 1'b0, 1'b0);
    endcase
  end
`endif

  // Pixel source select and blanking outside the active area.
  always_comb begin
    rgb_src_s = rgb_in;
    rgb_d     = '0;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      rgb_src_s = bar_rgb_s;
    end else begin
      rgb_src_s = rgb_in;
    end
`endif
    if (de_tap_s) begin
      rgb_d = rgb_src_s;
    end else begin
      rgb_d = '0;
    end
  end

  // State, delay-line and pixel registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      buf_sel_q <= 1'b0;
      hs_pipe_q <= {(PIPE_LAT+1){~H_POL}};
      vs_pipe_q <= {(PIPE_LAT+1){~V_POL}};
      de_pipe_q <= '0;
      rgb_q     <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      buf_sel_q <= buf_sel_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_pipe_q <= de_pipe_d;
      rgb_q     <= rgb_d;
    end
  end

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign fetch_valid = fetch_valid_s;
  assign frame_start = frame_start_s;
  assign swap_ack    = swap_ack_s;
  assign buf_sel     = buf_sel_q;
  assign hsync       = hs_pipe_q[PIPE_LAT];
  assign vsync       = vs_pipe_q[PIPE_LAT];
  assign de          = de_pipe_q[PIPE_LAT];
  assign red         = rgb_q[RGB_W-1 -: COLOR_W];
  assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_pipeline.sv
// Bench for vga_timing_pipeline on a small raster: a frame-position model predicts every
// output each cycle, and literal timing pins anchor the model on the scripted phases.
`timescale 1ns/1ps
module tb_vga_timing_pipeline;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam logic HP = 1'b1, VP = 1'b0;
  localparam int CW = 4, LAT = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                      3'b101, 3'b100, 3'b001, 3'b000};

  logic clk = 1'b0;
  logic rst, enable, swap_req, pattern_sel;
  logic [3*CW-1:0] rgb_in;
  logic [HW-1:0] pix_x;
  logic [VW-1:0] pix_y;
  logic fetch_valid, swap_ack, buf_sel, frame_start, hsync, vsync, de;
  logic [CW-1:0] red, green, blue;

  int checks = 0;
  int failures = 0;

  // model state
  int cyc = -1;
  int pos = 0;
  int last_rst = -1;
  logic mbuf = 1'b0;
  logic p_rst = 1'b1, p_en = 1'b0, p_ack = 1'b0;
  logic fv_h [16], hs_h [16], vs_h [16], pat_h [16];
  int x_h [16], y_h [16];
  logic [3*CW-1:0] rgbin_h [16];

  // expectations for the current cycle
  logic chk_on = 1'b0;
  int e_x, e_y;
  logic e_fv, e_fs, e_ack, e_buf, e_hs, e_vs, e_de;
  logic [3*CW-1:0] e_rgb;

  always #5 clk = ~clk;

  vga_timing_pipeline #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(HP), .V_POL(VP), .COLOR_W(CW), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .pix_x(pix_x), .pix_y(pix_y), .fetch_valid(fetch_valid), .rgb_in(rgb_in),
    .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [3*CW-1:0] bar_rgb(input int x);
    logic [2:0] c;
    c = BARS[(x * 8) / HA];
    return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
  endfunction

  // One pixel clock: advance the model, drive inputs, predict outputs.
  task automatic do_cycle(input logic r, input logic en, input logic sreq);
    int src, k, ci, pi, si;
    logic act, flushed;
    logic [3*CW-1:0] rv;
    @(posedge clk);
    #1;
    cyc++;
    if (p_rst || !p_en) pos = 0;
    else pos = (pos + 1) % FRAME;
    if (p_rst) mbuf = 1'b0;
    else if (p_ack) mbuf = ~mbuf;
    rst = r;
    enable = en;
    swap_req = sreq;
    act = en && !r;
    e_x = pos % HT;
    e_y = pos / HT;
    e_fv = act && (e_x < HA) && (e_y < VA);
    e_fs = act && (pos == 0);
    e_ack = act && (pos == FRAME - 1) && sreq;
    e_buf = mbuf;
    ci = cyc % 16;
    fv_h[ci] = e_fv;
    hs_h[ci] = (act && e_x >= HA + HFP && e_x < HA + HFP + HS) ? HP : ~HP;
    vs_h[ci] = (act && e_y >= VA + VFP && e_y < VA + VFP + VS) ? VP : ~VP;
    x_h[ci] = e_x;
    y_h[ci] = e_y;
    pat_h[ci] = pattern_sel;
    k = cyc - LAT;
    if (k >= 0 && fv_h[k % 16]) rv = {4'(x_h[k % 16]), 4'(y_h[k % 16]), 4'hA};
    else rv = 12'($urandom);
    rgb_in = rv;
    rgbin_h[ci] = rv;
    src = cyc - LAT - 1;
    flushed = (src < 0) || (last_rst >= src);
    if (flushed) begin
      e_hs = ~HP; e_vs = ~VP; e_de = 1'b0; e_rgb = '0;
    end else begin
      si = src % 16;
      pi = (cyc - 1) % 16;
      e_hs = hs_h[si];
      e_vs = vs_h[si];
      e_de = fv_h[si];
      if (!fv_h[si]) e_rgb = '0;
      else if (pat_h[pi]) e_rgb = bar_rgb(x_h[si]);
      else e_rgb = rgbin_h[pi];
    end
    if (r) last_rst = cyc;
    p_rst = r;
    p_en = en;
    p_ack = e_ack;
    chk_on = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Compare every DUT output against the model each cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pix_x", 32'(pix_x), 32'(e_x));
      chk("pix_y", 32'(pix_y), 32'(e_y));
      chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("swap_ack", 32'(swap_ack), 32'(e_ack));
      chk("buf_sel", 32'(buf_sel), 32'(e_buf));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("de", 32'(de), 32'(e_de));
      chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
    end
  end

  initial begin
    int t0, fs_first, fs_second, hs_first, hs_len, vs_first, vs_len;
    int acks, ack_x, ack_y, stage;
    logic sreq, rr, ee;
    bit found;
    rst = 1'b1; enable = 1'b0; swap_req = 1'b0; rgb_in = '0; pattern_sel = 1'b0;

    repeat (3) do_cycle(1'b1, 1'b1, 1'b0);

    // raster timing pins
    t0 = cyc + 1;
    fs_first = -1; fs_second = -1; hs_first = -1; hs_len = 0; vs_first = -1; vs_len = 0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0);
      if (frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = cyc;
        else if (fs_second < 0) fs_second = cyc;
      end
      if (hsync === HP) begin
        if (hs_first < 0) hs_first = cyc;
        if (cyc - t0 < HT + LAT + 1) hs_len++;
      end
      if (vsync === VP) begin
        if (vs_first < 0) vs_first = cyc;
        if (cyc - t0 >= LAT + 1 && cyc - t0 < FRAME + LAT + 1) vs_len++;
      end
      if (cyc == t0 + 77) begin
        chk("pixel_5_3_red", 32'(red), 32'd5);
        chk("pixel_5_3_green", 32'(green), 32'd3);
        chk("pixel_5_3_blue", 32'(blue), 32'd10);
        chk("pixel_5_3_de", 32'(de), 32'd1);
      end
      if (cyc == t0 + 19) begin
        chk("x16_de", 32'(de), 32'd0);
        chk("x16_rgb", 32'({red, green, blue}), 32'd0);
      end
    end
    chk("fs_first", fs_first - t0, 32'd0);
    chk("fs_period", fs_second - fs_first, 32'd230);
    chk("hs_start", hs_first - t0, 32'd21);
    chk("hs_len", hs_len, 32'd3);
    chk("vs_start", vs_first - t0, 32'd164);
    chk("vs_len", vs_len, 32'd46);

    // held swap request: one ack at the last pixel of the frame
    sreq = 1'b0; stage = 0; acks = 0; ack_x = -1; ack_y = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      do_cycle(1'b0, 1'b1, sreq);
      if (swap_ack === 1'b1) begin
        acks++; ack_x = int'(pix_x); ack_y = int'(pix_y);
      end
      case (stage)
        0: if (e_y == 2) begin sreq = 1'b1; stage = 1; end
        1: if (e_ack) stage = 2;
        2: begin sreq = 1'b0; stage = 3; end
        default: ;
      endcase
    end
    chk("swap_ack_count", acks, 32'd1);
    chk("swap_ack_x", ack_x, 32'd22);
    chk("swap_ack_y", ack_y, 32'd9);
    chk("buf_sel_after_swap", 32'(buf_sel), 32'd1);

    // request withdrawn before the boundary
    sreq = 1'b0; stage = 0; acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      do_cycle(1'b0, 1'b1, sreq);
      if (swap_ack === 1'b1) acks++;
      case (stage)
        0: if (e_y == 1) begin sreq = 1'b1; stage = 1; end
        1: if (e_y == 4) begin sreq = 1'b0; stage = 2; end
        default: ;
      endcase
    end
    chk("dropped_req_acks", acks, 32'd0);
    chk("buf_sel_kept", 32'(buf_sel), 32'd1);

    // mid-frame reset
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0);
      if (e_x == 10 && e_y == 4) found = 1'b1;
    end
    chk("rst_point_found", 32'(found), 32'd1);
    do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    chk("post_rst_x", 32'(pix_x), 32'd0);
    chk("post_rst_y", 32'(pix_y), 32'd0);
    chk("post_rst_hsync", 32'(hsync), 32'd0);
    chk("post_rst_vsync", 32'(vsync), 32'd1);
    chk("post_rst_de", 32'(de), 32'd0);
    chk("post_rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("post_rst_buf", 32'(buf_sel), 32'd0);

    // disable for 50 cycles, then restart at origin
    repeat (50) do_cycle(1'b0, 1'b0, 1'b0);
    chk("disabled_de", 32'(de), 32'd0);
    chk("disabled_x", 32'(pix_x), 32'd0);
    do_cycle(1'b0, 1'b1, 1'b0);
    chk("reenable_fs", 32'(frame_start), 32'd1);
    chk("reenable_x", 32'(pix_x), 32'd0);

    // randomized operation
    sreq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      ee = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) sreq = ~sreq;
`ifdef VGA_TEST_PATTERN_EN
      if ($urandom_range(0, 99) == 0) pattern_sel = ~pattern_sel;
`endif
      do_cycle(rr, ee, sreq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
